// File: rtl/sha256_pkg.sv
// Shared constants and types for the SHA-256 round datapath.
package sha256_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned DEF_TAG_W = 4;

    typedef logic [WORD_W-1:0] word_t;

endpackage

// File: rtl/csa_resolve_adder_if.sv
// Word handshake bundle between the compressor row, the resolve adder and the round controller.
interface csa_resolve_adder_if import sha256_pkg::*; #(
    parameter int unsigned WIDTH = WORD_W,
    parameter int unsigned TAG_W = DEF_TAG_W
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_sum;
    logic [WIDTH-1:0] in_carry;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_sum, in_carry, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_sum, in_carry, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );

endinterface

// File: rtl/csa_resolve_adder_cpa_slice.sv
// Combinational W-bit binary adder slice with carry in and carry out.
module cpa_slice #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout
);

    logic [W:0] total;

    assign total       = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign {cout, sum} = total;

endmodule

// File: rtl/csa_resolve_adder.sv
// Two-stage split-carry adder resolving a sum/carry redundant pair to a binary word.
// Low half is added in stage 1, high half plus the registered mid carry in stage 2.
module csa_resolve_adder import sha256_pkg::*; #(
    parameter int unsigned WIDTH = WORD_W,
    parameter int unsigned TAG_W = DEF_TAG_W
) (
    input logic                clk,
    input logic                rst_n,
    csa_resolve_adder_if.slave bus
);

    localparam int unsigned HALF_W = WIDTH / 2;

    logic [WIDTH-1:0]  carry_eff;
    logic [HALF_W-1:0] lo_sum;
    logic [HALF_W-1:0] hi_sum;
    logic              lo_cout;
    logic              hi_cout;
    logic              unused_bits;

    logic              s1_valid_q;
    logic              s1_cmid_q;
    logic [HALF_W-1:0] s1_lo_q;
    logic [HALF_W-1:0] s1_hi_sum_q;
    logic [HALF_W-1:0] s1_hi_carry_q;
    logic [TAG_W-1:0]  s1_tag_q;

    logic              s2_valid_q;
    logic [WIDTH-1:0]  s2_result_q;
    logic [TAG_W-1:0]  s2_tag_q;

    logic              s1_en;
    logic              s2_en;
    logic              accept;
    logic              s1_adv;

    // Carry bit i weighs 2^(i+1); the top carry bit and the final carry out fall off mod 2^WIDTH.
    assign carry_eff   = {bus.in_carry[WIDTH-2:0], 1'b0};
    assign unused_bits = ^{hi_cout, bus.in_carry[WIDTH-1]};

    assign s2_en  = ~s2_valid_q | bus.out_ready;
    assign s1_en  = ~s1_valid_q | s2_en;
    assign accept = bus.in_valid & s1_en;
    assign s1_adv = s1_valid_q & s2_en;

    cpa_slice #(.W(HALF_W)) u_lo (
        .a    (bus.in_sum[HALF_W-1:0]),
        .b    (carry_eff[HALF_W-1:0]),
        .cin  (1'b0),
        .sum  (lo_sum),
        .cout (lo_cout)
    );

    cpa_slice #(.W(HALF_W)) u_hi (
        .a    (s1_hi_sum_q),
        .b    (s1_hi_carry_q),
        .cin  (s1_cmid_q),
        .sum  (hi_sum),
        .cout (hi_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q    <= 1'b0;
            s1_cmid_q     <= 1'b0;
            s1_lo_q       <= '0;
            s1_hi_sum_q   <= '0;
            s1_hi_carry_q <= '0;
            s1_tag_q      <= '0;
        end else if (accept) begin
            s1_valid_q    <= 1'b1;
            s1_cmid_q     <= lo_cout;
            s1_lo_q       <= lo_sum;
            s1_hi_sum_q   <= bus.in_sum[WIDTH-1:HALF_W];
            s1_hi_carry_q <= carry_eff[WIDTH-1:HALF_W];
            s1_tag_q      <= bus.in_tag;
        end else if (s1_adv) begin
            s1_valid_q    <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_tag_q    <= '0;
        end else if (s1_adv) begin
            s2_valid_q  <= 1'b1;
            s2_result_q <= {hi_sum, s1_lo_q};
            s2_tag_q    <= s1_tag_q;
        end else if (s2_en) begin
            s2_valid_q  <= 1'b0;
        end
    end

    assign bus.in_ready   = s1_en;
    assign bus.out_valid  = s2_valid_q;
    assign bus.out_result = s2_result_q;
    assign bus.out_tag    = s2_tag_q;

endmodule

// File: tb/tb_csa_resolve_adder.sv
// Bench for csa_resolve_adder: directed vectors, corner sequences and a randomized scoreboard.
module tb_csa_resolve_adder;
    import sha256_pkg::*;

    localparam int unsigned TW = DEF_TAG_W;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    csa_resolve_adder_if #(.WIDTH(WORD_W), .TAG_W(TW)) bus ();

    csa_resolve_adder #(.WIDTH(WORD_W), .TAG_W(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        word_t         res;
        logic [TW-1:0] tag;
    } exp_t;

    typedef struct packed {
        word_t         s;
        word_t         c;
        logic [TW-1:0] t;
        word_t         r;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[8];
    int   n_pass = 0;
    int   n_total = 0;
    int   in_count = 0;
    int   out_count = 0;

    function automatic void check(input string name, input logic [63:0] act,
                                  input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    endfunction

    // Reference: plain modular arithmetic on the redundant pair.
    function automatic word_t ref_add(input word_t s, input word_t c);
        logic [WORD_W:0] full;
        full = {1'b0, s} + ({1'b0, c} << 1);
        return full[WORD_W-1:0];
    endfunction

    // Scoreboard: handshakes sampled on the falling edge, between active edges.
    bit            hold = 1'b0;
    word_t         held_res;
    logic [TW-1:0] held_tag;
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            hold = 1'b0;
        end else begin
            if (hold) begin
                check("hold_result", bus.out_result, held_res);
                check("hold_tag", bus.out_tag, held_tag);
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_t e;
                e.res = ref_add(bus.in_sum, bus.in_carry);
                e.tag = bus.in_tag;
                exp_q.push_back(e);
                in_count++;
            end
            if (bus.out_valid && bus.out_ready) begin
                out_count++;
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", bus.out_valid, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_result", bus.out_result, e.res);
                    check("out_tag", bus.out_tag, e.tag);
                end
            end
            hold     = bus.out_valid && !bus.out_ready;
            held_res = bus.out_result;
            held_tag = bus.out_tag;
        end
    end

    task automatic send(input word_t s, input word_t c, input logic [TW-1:0] t,
                        output int stalls);
        int n = 0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b1;
        bus.in_sum   = s;
        bus.in_carry = c;
        bus.in_tag   = t;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 50) begin
                check("send_timeout", bus.in_ready, 1);
                break;
            end
        end
        stalls = n;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(input int target, input string name);
        int n = 0;
        while (out_count < target && n < 300) begin
            @(negedge clk);
            n++;
        end
        check(name, out_count, target);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_total + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int tot;
        int base;
        int n;
        int seen;
        int discarded;
        bit acc;

        bus.in_valid  = 1'b0;
        bus.in_sum    = '0;
        bus.in_carry  = '0;
        bus.in_tag    = '0;
        bus.out_ready = 1'b1;

        vecs[0] = '{32'h0000FFFF, 32'h00000001, 4'h3, 32'h00010001};
        vecs[1] = '{32'hFFFFFFFF, 32'h80000000, 4'h5, 32'hFFFFFFFF};
        vecs[2] = '{32'hFFFFFFFF, 32'h00000001, 4'h6, 32'h00000001};
        vecs[3] = '{32'h00000000, 32'h00000000, 4'h0, 32'h00000000};
        vecs[4] = '{32'h12345678, 32'h11111111, 4'hA, 32'h3456789A};
        vecs[5] = '{32'hAAAAAAAA, 32'h55555555, 4'hF, 32'h55555554};
        vecs[6] = '{32'h7FFF7FFF, 32'h00004000, 4'h9, 32'h7FFFFFFF};
        vecs[7] = '{32'h0000FFFF, 32'h7FFF8000, 4'h1, 32'hFFFFFFFF};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_result", bus.out_result, 0);
        check("rst_out_tag", bus.out_tag, 0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_idle_out_valid", bus.out_valid, 0);

        // Directed vectors with exact 2-cycle latency
        for (int i = 0; i < 8; i++) begin
            send(vecs[i].s, vecs[i].c, vecs[i].t, st);
            idle();
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!bus.out_valid && n < 10);
            check($sformatf("vec%0d_latency", i), n, 2);
            check($sformatf("vec%0d_result", i), bus.out_result, vecs[i].r);
            check($sformatf("vec%0d_tag", i), bus.out_tag, vecs[i].t);
        end
        @(negedge clk);

        // Back-to-back streaming at full rate
        base = out_count;
        tot  = 0;
        for (int i = 0; i < 64; i++) begin
            send($urandom, $urandom, TW'(i % 16), st);
            tot += st;
        end
        idle();
        check("stream_stalls", tot, 0);
        wait_out(base + 64, "stream_count");
        check("stream_drained", exp_q.size(), 0);

        // Backpressure: out_ready low across cycles 3-7
        base = out_count;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    int s2;
                    send($urandom, $urandom, TW'(i + 8), s2);
                end
                idle();
            end
            begin
                repeat (3) @(posedge clk);
                #1 bus.out_ready = 1'b0;
                @(negedge clk);
                @(negedge clk);
                check("bp_in_ready_low", bus.in_ready, 0);
                check("bp_out_valid", bus.out_valid, 1);
                repeat (4) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        wait_out(base + 5, "bp_count");
        check("bp_drained", exp_q.size(), 0);

        // Reset with both stages full
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        send(32'hDEADBEEF, 32'h01234567, 4'h7, st);
        send(32'hCAFEF00D, 32'h76543210, 4'h8, st);
        idle();
        @(negedge clk);
        check("mid_full_out_valid", bus.out_valid, 1);
        check("mid_full_in_ready", bus.in_ready, 0);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_out_result", bus.out_result, 0);
        check("mid_rst_out_tag", bus.out_tag, 0);
        discarded = exp_q.size();
        exp_q.delete();
        in_count -= discarded;
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
        @(negedge clk);
        check("mid_rel_in_ready", bus.in_ready, 1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("mid_no_stale_word", seen, 0);

        // Random valid/ready toggling
        acc = 1'b1;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            @(posedge clk);
            #1;
            if (!bus.in_valid || acc) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                bus.in_sum   = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFF : $urandom;
                bus.in_carry = $urandom;
                bus.in_tag   = TW'($urandom);
            end
            bus.out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        wait_out(in_count, "rand_count_in_eq_out");
        check("rand_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
